fft_reorder_buf: RTL

Parametrised, double-buffered frame reorder stage for the streaming FFT datapath. It sits directly after an `fft_N` core and reorders each N-point complex frame from bit-reversed to natural order, or passes it through unchanged, while the next frame is being written. It generalises the fixed 64-point/4-lane ctrl-framed interface to any power-of-two N and lane count P. It adds per-frame mode selection, an explicit output valid and frame-abort handling.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_reorder_buf_if.sv | 27 ++
 rtl/fft_frame_bank.sv | 51 +++++
 rtl/fft_reorder_buf.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT datapath.
//   FFT_MODE_BITREV / FFT_MODE_NATURAL : per-frame reorder mode encodings
//   bitrev()   : reverse the low nbits of a value (width-generic)
//   lane_lsb() : bit offset of lane 'lane' in a lane-packed bus of w-bit lanes
package fft_pkg;

  localparam logic FFT_MODE_BITREV  = 1'b0;
  localparam logic FFT_MODE_NATURAL = 1'b1;

  // Shifts value bits in LSB-first, so bit 0 ends up at position nbits-1.
  function automatic logic [31:0] bitrev(input logic [31:0] value,
                                         input int unsigned nbits);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(nbits)) result = {result[30:0], value[i]};
    end
    return result;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/fft_reorder_buf_if.sv
// Streaming frame bus between an fft_N core and the reorder stage.
//   ctrl_in/mode_in/x_in/y_in    : upstream frame beats (P lanes of W bits)
//   x_out/y_out/ctrl_out/valid_out : reordered downstream beats
// master drives the inputs and observes the outputs; slave is the reorder stage.
interface fft_reorder_buf_if #(
  parameter int P = 4,
  parameter int W = 16
);
  logic           ctrl_in;
  logic           mode_in;
  logic [P*W-1:0] x_in;
  logic [P*W-1:0] y_in;
  logic [P*W-1:0] x_out;
  logic [P*W-1:0] y_out;
  logic           ctrl_out;
  logic           valid_out;

  modport master (
    output ctrl_in, mode_in, x_in, y_in,
    input  x_out, y_out, ctrl_out, valid_out
  );

  modport slave (
    input  ctrl_in, mode_in, x_in, y_in,
    output x_out, y_out, ctrl_out, valid_out
  );
endinterface

// File: rtl/fft_frame_bank.sv
// One N-entry complex sample bank (x and y planes, W bits each).
//   clk     : write clock
//   i_we    : write P lanes this cycle
//   i_base  : address of lane 0 (beat * P)
//   i_wx/i_wy : lane-packed write data
//   i_raddr : P independent read addresses, lane-packed LOGN bits each
//   o_rx/o_ry : lane-packed combinational read data
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int N = 64,
  parameter int P = 4,
  parameter int W = 16,
  localparam int LOGN = $clog2(N)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [LOGN-1:0]   i_base,
  input  logic [P*W-1:0]    i_wx,
  input  logic [P*W-1:0]    i_wy,
  input  logic [P*LOGN-1:0] i_raddr,
  output logic [P*W-1:0]    o_rx,
  output logic [P*W-1:0]    o_ry
);

  logic [W-1:0] r_mem_x [N];
  logic [W-1:0] r_mem_y [N];

  // NOTE: storage has no reset; a bank is only read after a full frame has
  // overwritten every entry, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int l = 0; l < P; l++) begin
        r_mem_x[i_base + LOGN'(l)] <= i_wx[lane_lsb(l, W) +: W];
        r_mem_y[i_base + LOGN'(l)] <= i_wy[lane_lsb(l, W) +: W];
      end
    end
  end

  // NOTE: outputs get a default before the loop so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_rx = '0;
    o_ry = '0;
    for (int l = 0; l < P; l++) begin
      o_rx[lane_lsb(l, W) +: W] = r_mem_x[i_raddr[l*LOGN +: LOGN]];
      o_ry[lane_lsb(l, W) +: W] = r_mem_y[i_raddr[l*LOGN +: LOGN]];
    end
  end

endmodule

// File: rtl/fft_reorder_buf.sv
// Double-buffered frame reorder stage: bit-reversed -> natural order, or
// pass-through, selected per frame. One bank is written while the other
// is read; they swap when a frame completes.
//   clk    : clock, rising edge
//   rst_in : asynchronous active-high reset
//   bus    : slave side of fft_reorder_buf_if (inputs ctrl/mode/x/y,
//            registered outputs x/y/ctrl/valid, zero when not valid)
module fft_reorder_buf
  import fft_pkg::*;
#(
  parameter int N = 64,
  parameter int P = 4,
  parameter int W = 16
) (
  input  logic            clk,
  input  logic            rst_in,
  fft_reorder_buf_if.slave bus
);

  localparam int F    = N / P;
  localparam int LOGN = $clog2(N);
  localparam int CW   = $clog2(F);
  localparam logic [CW-1:0] LAST = CW'(F - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  // Write side
  logic          r_wr_active;
  logic          r_wr_bank;
  logic          r_wr_mode;
  logic [CW-1:0] r_wc;
  // One-cycle handoff of a completed bank to the read side
  logic          r_hand;
  logic          r_hand_bank;
  logic          r_hand_mode;
  // Read side
  logic [0:0]    r_state;
  logic [CW-1:0] r_rc;
  logic          r_rd_bank;
  logic          r_rd_mode;
  // Registered outputs
  logic           r_valid;
  logic           r_ctrl;
  logic [P*W-1:0] r_x;
  logic [P*W-1:0] r_y;

  logic              w_we;
  logic              w_we_a;
  logic              w_we_b;
  logic [CW-1:0]     w_beat;
  logic [LOGN-1:0]   w_base;
  logic [LOGN-1:0]   w_k;
  logic [P*LOGN-1:0] w_raddr;
  logic [P*W-1:0]    w_a_x, w_a_y, w_b_x, w_b_y;
  logic [P*W-1:0]    w_rd_x, w_rd_y;

  // ctrl_in always writes beat 0, even if it interrupts a frame in progress.
  assign w_we   = bus.ctrl_in | r_wr_active;
  assign w_beat = bus.ctrl_in ? '0 : r_wc;
  assign w_base = LOGN'(int'(w_beat) * P);
  assign w_we_a = w_we & ~r_wr_bank;
  assign w_we_b = w_we &  r_wr_bank;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_wr_active <= 1'b0;
      r_wr_bank   <= 1'b0;
      r_wr_mode   <= FFT_MODE_BITREV;
      r_wc        <= '0;
      r_hand      <= 1'b0;
      r_hand_bank <= 1'b0;
      r_hand_mode <= FFT_MODE_BITREV;
    end else begin
      r_hand <= 1'b0;
      if (bus.ctrl_in) begin
        // A restart mid-frame reuses the same bank; the partial frame is lost.
        r_wr_active <= 1'b1;
        r_wr_mode   <= bus.mode_in;
        r_wc        <= CW'(1);
      end else if (r_wr_active) begin
        if (r_wc == LAST) begin
          r_wr_active <= 1'b0;
          r_wc        <= '0;
          r_hand      <= 1'b1;
          r_hand_bank <= r_wr_bank;
          r_hand_mode <= r_wr_mode;
          r_wr_bank   <= ~r_wr_bank;
        end else begin
          r_wc <= r_wc + CW'(1);
        end
      end
    end
  end

  // A handoff can only land while IDLE or on the last read beat, because a
  // frame takes F beats to write; loading unconditionally gives gapless
  // back-to-back output.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= ST_IDLE;
      r_rc      <= '0;
      r_rd_bank <= 1'b0;
      r_rd_mode <= FFT_MODE_BITREV;
    end else if (r_hand) begin
      r_state   <= ST_READ;
      r_rc      <= '0;
      r_rd_bank <= r_hand_bank;
      r_rd_mode <= r_hand_mode;
    end else if (r_state == ST_READ) begin
      if (r_rc == LAST) begin
        r_state <= ST_IDLE;
        r_rc    <= '0;
      end else begin
        r_rc <= r_rc + CW'(1);
      end
    end
  end

  // Output element k = rc*P + l comes from address bitrev(k) or k.
  always_comb begin
    w_raddr = '0;
    w_k     = '0;
    for (int l = 0; l < P; l++) begin
      w_k = LOGN'(int'(r_rc) * P + l);
      if (r_rd_mode == FFT_MODE_NATURAL) w_raddr[l*LOGN +: LOGN] = w_k;
      else w_raddr[l*LOGN +: LOGN] = LOGN'(bitrev(32'(w_k), LOGN));
    end
  end

  fft_frame_bank #(.N(N), .P(P), .W(W)) u_bank_a (
    .clk     (clk),
    .i_we    (w_we_a),
    .i_base  (w_base),
    .i_wx    (bus.x_in),
    .i_wy    (bus.y_in),
    .i_raddr (w_raddr),
    .o_rx    (w_a_x),
    .o_ry    (w_a_y)
  );

  fft_frame_bank #(.N(N), .P(P), .W(W)) u_bank_b (
    .clk     (clk),
    .i_we    (w_we_b),
    .i_base  (w_base),
    .i_wx    (bus.x_in),
    .i_wy    (bus.y_in),
    .i_raddr (w_raddr),
    .o_rx    (w_b_x),
    .o_ry    (w_b_y)
  );

  assign w_rd_x = r_rd_bank ? w_b_x : w_a_x;
  assign w_rd_y = r_rd_bank ? w_b_y : w_a_y;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_valid <= 1'b0;
      r_ctrl  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (r_state == ST_READ) begin
      r_valid <= 1'b1;
      r_ctrl  <= (r_rc == '0);
      r_x     <= w_rd_x;
      r_y     <= w_rd_y;
    end else begin
      r_valid <= 1'b0;
      r_ctrl  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end
  end

  assign bus.valid_out = r_valid;
  assign bus.ctrl_out  = r_ctrl;
  assign bus.x_out     = r_x;
  assign bus.y_out     = r_y;

endmodule
